msg_receive_wrapper: RTL and testbench

//  Downstream counterpart of msg_transmit_wrapper: drains the SRIO downstream byte FIFO, parses framed

---
 rtl/msg_receive_wrapper.sv | 199 +++++++++++++++++++
 tb/tb_msg_receive_wrapper.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_receive_wrapper.sv
// ---------------------------------------------------------------------------
// msg_receive_wrapper
//
// Drains the SRIO downstream byte FIFO, parses framed sensor messages and
// forwards payload bytes to per-channel cache FIFO write ports.
//
// Frame layout: 0x55 0xAA | CH_ID | LEN | LEN payload bytes | CHK
//   CHK = (CH_ID + LEN + sum(payload)) mod 256
//
// Ports
//   sys_clk_i        system clock
//   rst_i            synchronous reset, active-high
//   ds_empty_i       downstream FIFO empty
//   ds_rd_en_o       downstream FIFO read strobe (combinational)
//   ds_din_i         FIFO read data, valid one cycle after ds_rd_en_o
//   ch_prog_full_i   per-channel cache prog_full; any bit set stalls reads
//   ch_wr_en_o       one-hot payload write strobe
//   ch_wr_dout_o     payload byte, shared by all channels
//   frame_ok_o       single-cycle pulse: frame passed checksum
//   frame_err_o      single-cycle pulse: frame aborted/rejected
//   err_code_o       with frame_err_o: 1 bad ID, 2 bad LEN, 3 CHK, 4 timeout
//   frame_ch_o       CH_ID of the frame with a status pulse (0 if unknown)
//   frame_ok_cnt_o   saturating good-frame counter
//   frame_err_cnt_o  saturating bad-frame counter
// ---------------------------------------------------------------------------
module msg_receive_wrapper #(
    parameter int SENSOR_CHANNEL = 20,
    parameter int MAX_LEN        = 48,
    parameter int TIMEOUT_CYC    = 1000
) (
    input  logic                      sys_clk_i,
    input  logic                      rst_i,
    input  logic                      ds_empty_i,
    output logic                      ds_rd_en_o,
    input  logic [7:0]                ds_din_i,
    input  logic [SENSOR_CHANNEL-1:0] ch_prog_full_i,
    output logic [SENSOR_CHANNEL-1:0] ch_wr_en_o,
    output logic [7:0]                ch_wr_dout_o,
    output logic                      frame_ok_o,
    output logic                      frame_err_o,
    output logic [2:0]                err_code_o,
    output logic [7:0]                frame_ch_o,
    output logic [15:0]               frame_ok_cnt_o,
    output logic [15:0]               frame_err_cnt_o
);

    localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [7:0]    NCH      = 8'(SENSOR_CHANNEL);
    localparam logic [7:0]    MAXL     = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR2,
        ST_CHID,
        ST_LEN,
        ST_PAY,
        ST_CHK
    } state_t;

    state_t                    state_q;
    logic                      byte_vld_q;   // read issued last cycle: ds_din_i holds a byte
    logic [7:0]                id_q;
    logic [7:0]                len_q;
    logic [7:0]                cnt_q;
    logic [7:0]                sum_q;
    logic [TW-1:0]             timer_q;
    logic [SENSOR_CHANNEL-1:0] ch_wr_en_q;
    logic [7:0]                ch_wr_dout_q;
    logic                      frame_ok_q;
    logic                      frame_err_q;
    logic [2:0]                err_code_q;
    logic [7:0]                frame_ch_q;
    logic [15:0]               ok_cnt_q;
    logic [15:0]               err_cnt_q;

    // One-hot decode of the latched channel id for the payload strobe.
    logic [SENSOR_CHANNEL-1:0] wr_sel_d;
    genvar gi;
    generate
        for (gi = 0; gi < SENSOR_CHANNEL; gi++) begin : g_sel
            assign wr_sel_d[gi] = (id_q == 8'(gi));
        end
    endgenerate

    // Reads stall while any downstream cache is near full, regardless of
    // which channel the current frame targets.
    assign ds_rd_en_o = !rst_i && !ds_empty_i && !(|ch_prog_full_i);

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            byte_vld_q   <= 1'b0;
            id_q         <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            sum_q        <= '0;
            timer_q      <= '0;
            ch_wr_en_q   <= '0;
            ch_wr_dout_q <= '0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= '0;
            frame_ch_q   <= '0;
            ok_cnt_q     <= '0;
            err_cnt_q    <= '0;
        end else begin
            byte_vld_q  <= ds_rd_en_o;
            ch_wr_en_q  <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
            frame_ch_q  <= '0;

            if (byte_vld_q) begin
                // An arriving byte always takes priority over timer expiry.
                timer_q <= '0;
                unique case (state_q)
                    ST_IDLE: begin
                        if (ds_din_i == 8'h55) state_q <= ST_HDR2;
                    end
                    ST_HDR2: begin
                        if (ds_din_i == 8'hAA)      state_q <= ST_CHID;
                        else if (ds_din_i != 8'h55) state_q <= ST_IDLE;
                    end
                    ST_CHID: begin
                        if (ds_din_i < NCH) begin
                            id_q    <= ds_din_i;
                            sum_q   <= ds_din_i;
                            state_q <= ST_LEN;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= 3'd1;
                            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
                            state_q     <= ST_IDLE;
                        end
                    end
                    ST_LEN: begin
                        if (ds_din_i != 8'd0 && ds_din_i <= MAXL) begin
                            len_q   <= ds_din_i;
                            sum_q   <= sum_q + ds_din_i;
                            cnt_q   <= '0;
                            state_q <= ST_PAY;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= 3'd2;
                            frame_ch_q  <= id_q;
                            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
                            state_q     <= ST_IDLE;
                        end
                    end
                    ST_PAY: begin
                        ch_wr_en_q   <= wr_sel_d;
                        ch_wr_dout_q <= ds_din_i;
                        sum_q        <= sum_q + ds_din_i;
                        if (cnt_q == len_q - 8'd1) state_q <= ST_CHK;
                        else                       cnt_q   <= cnt_q + 8'd1;
                    end
                    ST_CHK: begin
                        frame_ch_q <= id_q;
                        if (ds_din_i == sum_q) begin
                            frame_ok_q <= 1'b1;
                            if (ok_cnt_q != 16'hFFFF) ok_cnt_q <= ok_cnt_q + 16'd1;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= 3'd3;
                            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
                        end
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (state_q != ST_IDLE) begin
                if (timer_q == TMO_LAST) begin
                    frame_err_q <= 1'b1;
                    err_code_q  <= 3'd4;
                    // The id is only known once the CH_ID byte was accepted.
                    frame_ch_q  <= (state_q == ST_HDR2 || state_q == ST_CHID) ? 8'd0 : id_q;
                    if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
                    timer_q     <= '0;
                    state_q     <= ST_IDLE;
                end else begin
                    timer_q <= timer_q + TMO_ONE;
                end
            end
        end
    end

    assign ch_wr_en_o      = ch_wr_en_q;
    assign ch_wr_dout_o    = ch_wr_dout_q;
    assign frame_ok_o      = frame_ok_q;
    assign frame_err_o     = frame_err_q;
    assign err_code_o      = err_code_q;
    assign frame_ch_o      = frame_ch_q;
    assign frame_ok_cnt_o  = ok_cnt_q;
    assign frame_err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_msg_receive_wrapper.sv
// ---------------------------------------------------------------------------
// tb_msg_receive_wrapper
//
// Drives msg_receive_wrapper from a queue acting as the downstream FIFO and
// compares every cycle against a frame-buffer reference model: bytes of the
// current candidate frame are collected and judged by their position in the
// buffer, and the checksum is recomputed as a plain sum over the buffer.
// Directed scenarios come first, then randomized frames with random
// prog_full stalls, split deliveries and truncated (timed-out) frames.
// ---------------------------------------------------------------------------
module tb_msg_receive_wrapper;

    localparam int NCH  = 20;
    localparam int MAXL = 48;
    localparam int TMO  = 1000;

    logic            clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_i          = 1'b1;
    logic            ds_empty_i     = 1'b1;
    logic            ds_rd_en_o;
    logic [7:0]      ds_din_i       = 8'd0;
    logic [NCH-1:0]  ch_prog_full_i = '0;
    logic [NCH-1:0]  ch_wr_en_o;
    logic [7:0]      ch_wr_dout_o;
    logic            frame_ok_o;
    logic            frame_err_o;
    logic [2:0]      err_code_o;
    logic [7:0]      frame_ch_o;
    logic [15:0]     frame_ok_cnt_o;
    logic [15:0]     frame_err_cnt_o;

    msg_receive_wrapper #(
        .SENSOR_CHANNEL (NCH),
        .MAX_LEN        (MAXL),
        .TIMEOUT_CYC    (TMO)
    ) dut (
        .sys_clk_i       (clk),
        .rst_i           (rst_i),
        .ds_empty_i      (ds_empty_i),
        .ds_rd_en_o      (ds_rd_en_o),
        .ds_din_i        (ds_din_i),
        .ch_prog_full_i  (ch_prog_full_i),
        .ch_wr_en_o      (ch_wr_en_o),
        .ch_wr_dout_o    (ch_wr_dout_o),
        .frame_ok_o      (frame_ok_o),
        .frame_err_o     (frame_err_o),
        .err_code_o      (err_code_o),
        .frame_ch_o      (frame_ch_o),
        .frame_ok_cnt_o  (frame_ok_cnt_o),
        .frame_err_cnt_o (frame_err_cnt_o)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]     fifo_q[$];     // downstream FIFO contents
    logic [7:0]     fb[$];         // candidate frame collected by the model
    bit             drv_rst = 1'b1;
    logic [NCH-1:0] drv_pf  = '0;
    bit             rand_pf = 1'b0;
    bit             acc_pending = 1'b0;  // a read was issued at the last edge
    int             m_idle    = 0;
    int             m_ok_cnt  = 0;
    int             m_err_cnt = 0;

    logic [NCH-1:0] exp_wr   = '0;
    logic [7:0]     exp_dout = 8'd0;
    bit             exp_ok   = 1'b0;
    bit             exp_err  = 1'b0;
    logic [2:0]     exp_code = 3'd0;
    logic [7:0]     exp_ch   = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic void emit(input bit ok, input logic [2:0] code, input logic [7:0] ch);
        exp_ch = ch;
        if (ok) begin
            exp_ok = 1'b1;
            if (m_ok_cnt < 65535) m_ok_cnt++;
        end else begin
            exp_err  = 1'b1;
            exp_code = code;
            if (m_err_cnt < 65535) m_err_cnt++;
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int n;
        int plen;
        int s;
        m_idle = 0;
        n = fb.size();
        if (n == 0) begin
            if (b == 8'h55) fb.push_back(b);
        end else if (n == 1) begin
            if (b == 8'hAA)      fb.push_back(b);
            else if (b != 8'h55) fb.delete();
        end else if (n == 2) begin
            if (int'(b) < NCH) fb.push_back(b);
            else begin emit(1'b0, 3'd1, 8'd0); fb.delete(); end
        end else if (n == 3) begin
            if (b >= 8'd1 && int'(b) <= MAXL) fb.push_back(b);
            else begin emit(1'b0, 3'd2, fb[2]); fb.delete(); end
        end else begin
            plen = int'(fb[3]);
            if (n < 4 + plen) begin
                fb.push_back(b);
                exp_wr        = '0;
                exp_wr[fb[2]] = 1'b1;
                exp_dout      = b;
            end else begin
                s = 0;
                for (int i = 2; i < n; i++) s += int'(fb[i]);
                if (b == 8'(s)) emit(1'b1, 3'd0, fb[2]);
                else            emit(1'b0, 3'd3, fb[2]);
                fb.delete();
            end
        end
    endfunction

    function automatic void model_idle();
        if (fb.size() != 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                emit(1'b0, 3'd4, (fb.size() >= 3) ? fb[2] : 8'd0);
                fb.delete();
                m_idle = 0;
            end
        end
    endfunction

    // One clock cycle: check the outputs of the edge just passed, then apply
    // inputs and advance the model to what the next edge should produce.
    task automatic tick();
        logic [7:0] b;
        bit         exp_rd;
        @(negedge clk);
        chk("wr_en", 32'(ch_wr_en_o), 32'(exp_wr));
        if (exp_wr != '0) chk("wr_dout", 32'(ch_wr_dout_o), 32'(exp_dout));
        chk("frame_ok", 32'(frame_ok_o), 32'(exp_ok));
        chk("frame_err", 32'(frame_err_o), 32'(exp_err));
        if (exp_ok || exp_err) chk("frame_ch", 32'(frame_ch_o), 32'(exp_ch));
        if (exp_err) chk("err_code", 32'(err_code_o), 32'(exp_code));
        chk("ok_cnt", 32'(frame_ok_cnt_o), 32'(m_ok_cnt));
        chk("err_cnt", 32'(frame_err_cnt_o), 32'(m_err_cnt));
        exp_wr  = '0;
        exp_ok  = 1'b0;
        exp_err = 1'b0;

        if (rand_pf) drv_pf = ($urandom_range(0, 7) == 0) ? (NCH'(1) << $urandom_range(0, NCH - 1)) : '0;
        rst_i          = drv_rst;
        ch_prog_full_i = drv_pf;
        b = ds_din_i;
        if (acc_pending) begin
            b        = fifo_q.pop_front();
            ds_din_i = b;
        end
        ds_empty_i = (fifo_q.size() == 0);
        exp_rd = !drv_rst && !ds_empty_i && (drv_pf == '0);
        #1;
        chk("rd_en", 32'(ds_rd_en_o), 32'(exp_rd));
        if (drv_rst) begin
            fb.delete();
            m_idle    = 0;
            m_ok_cnt  = 0;
            m_err_cnt = 0;
        end else if (acc_pending) begin
            model_byte(b);
        end else begin
            model_idle();
        end
        acc_pending = exp_rd;
    endtask

    task automatic push(input logic [7:0] bytes[$]);
        foreach (bytes[i]) fifo_q.push_back(bytes[i]);
    endtask

    task automatic drain(input int extra);
        int guard = 0;
        while ((fifo_q.size() != 0 || acc_pending) && guard < 5000) begin
            tick();
            guard++;
        end
        chk("drain_bound", 32'(guard < 5000), 32'd1);
        repeat (extra) tick();
    endtask

    task automatic send_rand_frame();
        logic [7:0] fr[$];
        logic [7:0] ch;
        logic [7:0] len;
        logic [7:0] b;
        int         s;
        bit         trunc;
        if ($urandom_range(0, 4) == 0)
            repeat ($urandom_range(1, 3)) fr.push_back(8'($urandom_range(0, 255)));
        ch  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(NCH, 255)) : 8'($urandom_range(0, NCH - 1));
        len = ($urandom_range(0, 11) == 0) ?
              (($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAXL + 1, 255))) :
              8'($urandom_range(1, MAXL));
        fr.push_back(8'h55);
        fr.push_back(8'hAA);
        fr.push_back(ch);
        fr.push_back(len);
        s = int'(ch) + int'(len);
        if (int'(ch) < NCH && len != 8'd0 && int'(len) <= MAXL) begin
            for (int i = 0; i < int'(len); i++) begin
                b = 8'($urandom_range(0, 255));
                fr.push_back(b);
                s += int'(b);
            end
            fr.push_back(($urandom_range(0, 5) == 0) ? 8'(s + 1) : 8'(s));
        end
        trunc = (fr.size() > 6) && ($urandom_range(0, 39) == 0);
        if (trunc) begin
            int keep = $urandom_range(4, fr.size() - 2);
            while (fr.size() > keep) void'(fr.pop_back());
        end
        foreach (fr[i]) begin
            fifo_q.push_back(fr[i]);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
        end
        drain($urandom_range(0, 3));
        if (trunc) repeat (TMO + 3) tick();
    endtask

    initial begin
        int g;

        // Reset: all outputs zero.
        drv_rst = 1'b1;
        repeat (3) tick();
        chk("rst_dout", 32'(ch_wr_dout_o), 32'd0);
        chk("rst_frame_ch", 32'(frame_ch_o), 32'd0);
        chk("rst_err_code", 32'(err_code_o), 32'd0);
        drv_rst = 1'b0;
        tick();

        // Good frame to channel 3.
        push('{8'h55, 8'hAA, 8'h03, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA7});
        drain(3);
        chk("t1_ok_cnt", 32'(frame_ok_cnt_o), 32'd1);

        // Same frame with a wrong checksum.
        push('{8'h55, 8'hAA, 8'h03, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'hB8});
        drain(3);
        chk("t2_err_cnt", 32'(frame_err_cnt_o), 32'd1);

        // Bad id, zero length, over-long length.
        push('{8'h55, 8'hAA, 8'h14});
        push('{8'h55, 8'hAA, 8'h02, 8'h00});
        push('{8'h55, 8'hAA, 8'h02, 8'h31});
        drain(3);
        chk("t3_err_cnt", 32'(frame_err_cnt_o), 32'd4);

        // Garbage then resync.
        push('{8'h00, 8'h55, 8'h55, 8'hAA, 8'h01, 8'h01, 8'h7F, 8'h81});
        drain(3);
        chk("t4_ok_cnt", 32'(frame_ok_cnt_o), 32'd2);

        // Starve after LEN: timeout, then a normal frame.
        push('{8'h55, 8'hAA, 8'h03, 8'h04});
        drain(0);
        repeat (TMO + 5) tick();
        chk("t5_err_cnt", 32'(frame_err_cnt_o), 32'd5);
        push('{8'h55, 8'hAA, 8'h03, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA7});
        drain(3);
        chk("t5_ok_cnt", 32'(frame_ok_cnt_o), 32'd3);

        // Byte arriving on the very cycle the timer would expire.
        push('{8'h55, 8'hAA, 8'h03, 8'h02, 8'h11});
        drain(0);
        g = 0;
        while (m_idle != TMO - 2 && g < 2 * TMO) begin
            tick();
            g++;
        end
        chk("edge_bound", 32'(g < 2 * TMO), 32'd1);
        push('{8'h22, 8'h38});
        drain(3);
        chk("edge_ok_cnt", 32'(frame_ok_cnt_o), 32'd4);
        chk("edge_err_cnt", 32'(frame_err_cnt_o), 32'd5);

        // prog_full stall, then reset in the middle of the payload.
        drv_pf = NCH'(1) << 5;
        push('{8'h55, 8'hAA, 8'h03, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA7});
        repeat (10) tick();
        drv_pf = '0;
        repeat (6) tick();
        drv_rst = 1'b1;
        repeat (2) tick();
        drv_rst = 1'b0;
        drain(3);
        chk("t6_ok_cnt", 32'(frame_ok_cnt_o), 32'd0);

        // Randomized frames with random stalls.
        rand_pf = 1'b1;
        repeat (150) send_rand_frame();
        rand_pf = 1'b0;
        drv_pf  = '0;
        drain(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
